// File: rtl/mem_handshake_sync.sv
// N-port memory-handshake synchroniser: per-port IDLE/WAIT/DONE request gating, global
// pipeline freeze, saturating per-port stall counters and a sticky per-port watchdog.
module mem_handshake_sync #(
    parameter int NUM_PORTS   = 2,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_PORTS-1:0]       req_i,
    input  logic [NUM_PORTS-1:0]       ready_i,
    input  logic                       cnt_clr_i,
    output logic [NUM_PORTS-1:0]       req_en_o,
    output logic [NUM_PORTS-1:0]       port_stall_o,
    output logic                       stall_o,
    output logic [2*NUM_PORTS-1:0]     state_o,
    output logic [CNT_W*NUM_PORTS-1:0] stall_cnt_o,
    output logic [NUM_PORTS-1:0]       timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int WR_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WR_W-1:0] WR_MAX = WR_W'(TIMEOUT_CYC);

    state_t               state_q [NUM_PORTS];
    state_t               state_d [NUM_PORTS];
    logic [CNT_W-1:0]     stall_cnt_q [NUM_PORTS];
    logic [NUM_PORTS-1:0] req_en;
    logic [NUM_PORTS-1:0] port_stall;
    logic                 stall;

    // A port parked in DONE must not re-issue its already-completed access.
    always_comb begin
        req_en     = '0;
        port_stall = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            req_en[k]     = req_i[k] & (state_q[k] != DONE);
            port_stall[k] = req_en[k] & ~ready_i[k];
        end
        stall = |port_stall;
    end

    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            state_d[k] = IDLE;
            // NOTE: the illegal 2'b11 code lands in default and recovers to IDLE; every path assigns state_d, so no latch.
            case (state_q[k])
                IDLE, WAIT, DONE: begin
                    if (port_stall[k])  state_d[k] = WAIT;
                    else if (stall)     state_d[k] = DONE;
                    else                state_d[k] = IDLE;
                end
                default: state_d[k] = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_PORTS; k++) state_q[k] <= IDLE;
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) state_q[k] <= state_d[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_PORTS; k++) stall_cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (cnt_clr_i)
                    stall_cnt_q[k] <= '0;
                else if (port_stall[k] && (stall_cnt_q[k] != '1))
                    stall_cnt_q[k] <= stall_cnt_q[k] + 1'b1;
            end
        end
    end

    generate
        if (TIMEOUT_CYC > 0) begin : g_watchdog
            logic [WR_W-1:0] wait_run_q [NUM_PORTS];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < NUM_PORTS; k++) wait_run_q[k] <= '0;
                end else begin
                    for (int k = 0; k < NUM_PORTS; k++) begin
                        if (!port_stall[k])
                            wait_run_q[k] <= '0;
                        else if (wait_run_q[k] != WR_MAX)
                            wait_run_q[k] <= wait_run_q[k] + 1'b1;
                    end
                end
            end

            // Fires only on the transition into WR_MAX, so a clear during a long stall sticks.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    timeout_o <= '0;
                end else begin
                    for (int k = 0; k < NUM_PORTS; k++) begin
                        if (cnt_clr_i)
                            timeout_o[k] <= 1'b0;
                        else if (port_stall[k] && (wait_run_q[k] == WR_MAX - WR_W'(1)))
                            timeout_o[k] <= 1'b1;
                    end
                end
            end
        end else begin : g_no_watchdog
            assign timeout_o = '0;
        end
    endgenerate

    generate
        for (genvar k = 0; k < NUM_PORTS; k++) begin : g_pack
            assign state_o[2*k +: 2]             = state_q[k];
            assign stall_cnt_o[k*CNT_W +: CNT_W] = stall_cnt_q[k];
        end
    endgenerate

    assign req_en_o     = req_en;
    assign port_stall_o = port_stall;
    assign stall_o      = stall;

endmodule
